wb_burst_master: RTL and testbench

- Wishbone B3 burst master sitting directly upstream of the SDRAM controller's Wishbone slave port (wb_stb_i/wb_cyc_i/wb_cti_i/...).
- Converts a command stream (read/write, start address, burst length) plus a write-data stream into incrementing-burst Wishbone cycles.
- Returns read data as a valid-only stream.
- Replaces ad-hoc task-driven stimulus with a synthesizable, cycle-exact traffic source.

---
 rtl/wbm_pkg.sv | 19 +
 rtl/wb_burst_master_if.sv | 25 ++
 rtl/wbm_sync_fifo.sv | 55 +++++
 rtl/wb_burst_master.sv | 176 +++++++++++++++++
 tb/tb_wb_burst_master.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wbm_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wbm_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int CMD_AW  = 32;
  localparam int CMD_BLW = 5;

  typedef enum logic [1:0] {IDLE, WR, RD, DONE} wbm_state_e;

  typedef struct packed {
    logic              we;
    logic [CMD_AW-1:0] addr;
    logic [CMD_BLW-1:0] bl;
  } wbm_cmd_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and the SDRAM controller slave port.
interface wb_burst_master_if #(
  parameter int DW = 32,
  parameter int AW = 32
) ();
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic          wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wbm_sync_fifo.sv
// Synchronous FIFO with registered full/empty flags, sync active-low reset and flush.
module wbm_sync_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic         clk_sys,
  input  logic         rst_b,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count, count_nxt;
  logic          do_push, do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + (PW+1)'(1);
    else if (!do_push && do_pop)
      count_nxt = count - (PW+1)'(1);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (PW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B3 incrementing-burst master with write-data FIFO.
// Define WBM_TIMEOUT_EN to add the no-ack watchdog and its err pulse.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WR    | write burst in progress, stb follows FIFO non-empty
// RD    | read burst in progress, stb held high
// DONE  | one-cycle completion pulse, bus released
module wb_burst_master
  import wbm_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int BLW         = 5,
  parameter int WFIFO_DEPTH = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic             sys_clk,
  input  logic             RESETN,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [BLW-1:0]   cmd_bl,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [DW-1:0]    wdat_data,
  input  logic [DW/8-1:0]  wdat_sel,
  output logic             rdat_valid,
  output logic [DW-1:0]    rdat_data,
  output logic             busy,
  output logic             done,
  wb_burst_master_if.master wb
`ifdef WBM_TIMEOUT_EN
  , output logic           err
`endif
);
  localparam int FW = DW + DW/8;

  wbm_state_e state, state_nxt;
  wbm_cmd_t   cmd_q;

  logic [FW-1:0]   fifo_rd;
  logic            fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [BLW-1:0]  bl_eff;
  logic            last, beat_ack;
  logic            cyc, stb;
  logic [DW-1:0]   dat;
  logic [DW/8-1:0] sel;

  assign wdat_ready = !fifo_full;
  assign fifo_push  = wdat_valid && wdat_ready;

  wbm_sync_fifo #(
    .W     (FW),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk_sys   (sys_clk),
    .rst_b     (RESETN),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data ({wdat_sel, wdat_data}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bl_eff = (cmd_bl == '0) ? BLW'(1) : cmd_bl;
  assign last   = (cmd_q.bl == CMD_BLW'(1));

`ifdef WBM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;
`endif

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    cyc       = 1'b0;
    stb       = 1'b0;
    dat       = '0;
    sel       = '0;
    fifo_pop  = 1'b0;
    beat_ack  = 1'b0;
`ifdef WBM_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = cmd_we ? WR : RD;
      end
      WR: begin
        cyc      = 1'b1;
        stb      = !fifo_empty;
        dat      = stb ? fifo_rd[DW-1:0] : '0;
        sel      = stb ? fifo_rd[FW-1:DW] : '0;
        beat_ack = stb && wb.wb_ack_i;
        fifo_pop = beat_ack;
        if (beat_ack && last) state_nxt = DONE;
      end
      RD: begin
        cyc      = 1'b1;
        stb      = 1'b1;
        sel      = '1;
        beat_ack = wb.wb_ack_i;
        if (beat_ack && last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef WBM_TIMEOUT_EN
    // Watchdog abort overrides the burst: the counter would reach the limit on this edge.
    if (stb && !wb.wb_ack_i && wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
      timeout_hit = 1'b1;
      state_nxt   = IDLE;
    end
`endif
  end

`ifdef WBM_TIMEOUT_EN
  assign fifo_flush = timeout_hit;
`else
  assign fifo_flush = 1'b0;
`endif

  always_ff @(posedge sys_clk) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      cmd_q      <= '0;
      rdat_valid <= 1'b0;
      rdat_data  <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        cmd_q <= '{we:   cmd_we,
                   addr: CMD_AW'(cmd_addr & ~AW'(DW/8 - 1)),
                   bl:   CMD_BLW'(bl_eff)};
      end else if (beat_ack) begin
        cmd_q.bl   <= cmd_q.bl - CMD_BLW'(1);
        cmd_q.addr <= cmd_q.addr + CMD_AW'(DW/8);
      end
      rdat_valid <= (state == RD) && beat_ack;
      if ((state == RD) && beat_ack) rdat_data <= wb.wb_dat_i;
    end
  end

`ifdef WBM_TIMEOUT_EN
  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (timeout_hit || beat_ack || !cyc) wd_cnt <= '0;
      else if (stb)                        wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign wb.wb_cyc_o  = cyc;
  assign wb.wb_stb_o  = stb;
  assign wb.wb_we_o   = cyc && cmd_q.we;
  assign wb.wb_addr_o = cyc ? AW'(cmd_q.addr) : '0;
  assign wb.wb_dat_o  = dat;
  assign wb.wb_sel_o  = sel;
  assign wb.wb_cti_o  = !cyc ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INCR);
endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: command table, scoreboard queues, slave model.
module tb_wb_burst_master;
  logic        sys_clk;
  logic        RESETN;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr;
  logic [4:0]  cmd_bl;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat_data;
  logic [3:0]  wdat_sel;
  logic        rdat_valid;
  logic [31:0] rdat_data;
  logic        busy, done;
`ifdef WBM_TIMEOUT_EN
  logic        err;
`endif

  wb_burst_master_if #(.DW(32), .AW(32)) wb ();

  wb_burst_master #(
    .DW(32), .AW(32), .BLW(5), .WFIFO_DEPTH(8), .TIMEOUT_CYC(16)
  ) dut (
    .sys_clk    (sys_clk),
    .RESETN     (RESETN),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_addr   (cmd_addr),
    .cmd_bl     (cmd_bl),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat_data  (wdat_data),
    .wdat_sel   (wdat_sel),
    .rdat_valid (rdat_valid),
    .rdat_data  (rdat_data),
    .busy       (busy),
    .done       (done),
    .wb         (wb)
`ifdef WBM_TIMEOUT_EN
    , .err      (err)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [31:0] addr; logic [2:0] cti; logic we; } beat_t;
  typedef struct { logic [31:0] dat; logic [3:0] sel; } wword_t;
  typedef struct { logic we; logic [31:0] addr; logic [4:0] bl; int nw; int ws; int exp_nb; } vec_t;

  beat_t       exp_beats[$];
  wword_t      wq[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_rd[$];

  int n_checks = 0;
  int n_errs   = 0;
  int done_cnt = 0;
  int beats_seen = 0;
  int wait_states = 0;
  bit never_ack = 0;
  int wcnt = 0;
  int wk = 0;
  logic [31:0] wval = 32'hA0;
  logic [31:0] rdv  = 32'hA0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errs++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Slave model: ack after wait_states stalled cycles; read data from rd_q.
  always @(posedge sys_clk) begin
    #1;
    if (wb.wb_ack_i || !(wb.wb_cyc_o && wb.wb_stb_o)) begin
      wb.wb_ack_i = 1'b0;
      wcnt = 0;
    end
    if (wb.wb_cyc_o && wb.wb_stb_o && !wb.wb_ack_i && !never_ack) begin
      if (wcnt >= wait_states) begin
        wb.wb_ack_i = 1'b1;
        if (!wb.wb_we_o && rd_q.size() > 0) wb.wb_dat_i = rd_q.pop_front();
        else                                wb.wb_dat_i = 32'h0BAD_0BAD;
      end else begin
        wcnt++;
      end
    end
  end

  // Monitor on the falling edge: beat scoreboard, read-return latency, done timing.
  bit     prev_rd_ack = 0;
  bit     prev_last_ack = 0;
  bit     cur_beat;
  beat_t  mb;
  wword_t mw;
  always @(negedge sys_clk) begin
    if (!RESETN) begin
      prev_rd_ack   = 0;
      prev_last_ack = 0;
    end else begin
      if (prev_rd_ack || rdat_valid) begin
        check("rdat_valid_latency", rdat_valid, prev_rd_ack);
        if (rdat_valid) begin
          if (exp_rd.size() == 0) fail("rdat_unexpected");
          else check("rdat_data", rdat_data, exp_rd.pop_front());
        end
      end
      if (prev_last_ack || done) check("done_timing", done, prev_last_ack);
      if (done) done_cnt++;
      cur_beat = wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i;
      if (cur_beat) begin
        beats_seen++;
        if (exp_beats.size() == 0) fail("beat_unexpected");
        else begin
          mb = exp_beats.pop_front();
          check("beat_addr", wb.wb_addr_o, mb.addr);
          check("beat_cti", wb.wb_cti_o, mb.cti);
          check("beat_we", wb.wb_we_o, mb.we);
          if (mb.we) begin
            if (wq.size() == 0) fail("wdata_missing");
            else begin
              mw = wq.pop_front();
              check("beat_wdat", wb.wb_dat_o, mw.dat);
              check("beat_wsel", wb.wb_sel_o, mw.sel);
            end
          end else begin
            check("beat_rd_sel", wb.wb_sel_o, 4'hF);
            check("beat_rd_dat", wb.wb_dat_o, 32'h0);
          end
        end
      end
      prev_rd_ack   = cur_beat && !wb.wb_we_o;
      prev_last_ack = cur_beat && (wb.wb_cti_o == 3'b111);
    end
  end

  task automatic push_word();
    logic [3:0] s;
    bit ok;
    bit r;
    s = 4'((wk * 5 + 15) % 16);
    wdat_valid = 1'b1;
    wdat_data  = wval;
    wdat_sel   = s;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      r = wdat_ready;
      tick();
      if (r) begin ok = 1; break; end
    end
    wdat_valid = 1'b0;
    if (!ok) fail("wdat_push_timeout");
    else wq.push_back('{wval, s});
    wval = wval + 32'h1;
    wk++;
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] addr, input logic [4:0] bl);
    int n;
    logic [31:0] base;
    bit ok;
    bit r;
    n = (bl == 5'd0) ? 1 : int'(bl);
    base = addr & 32'hFFFF_FFFC;
    for (int i = 0; i < n; i++) begin
      exp_beats.push_back('{base + 32'(4 * i), (i == n - 1) ? 3'b111 : 3'b010, we});
      if (!we) begin
        rd_q.push_back(rdv);
        exp_rd.push_back(rdv);
        rdv = rdv + 32'h1;
      end
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_bl    = bl;
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      r = cmd_ready;
      tick();
      if (r) begin ok = 1; break; end
    end
    cmd_valid = 1'b0;
    if (!ok) fail("cmd_accept_timeout");
  endtask

  task automatic wait_done(input int d0);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      tick();
    end
    if (!ok) fail("done_timeout");
  endtask

  vec_t vecs[9];
  int d0, b0;

  initial begin
    RESETN = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_bl = '0;
    wdat_valid = 0; wdat_data = '0; wdat_sel = '0;
    wb.wb_ack_i = 1'b0; wb.wb_dat_i = '0;

    vecs[0] = '{1'b1, 32'h0000_0100, 5'd4, 4, 0, 4};
    vecs[1] = '{1'b0, 32'h0000_0100, 5'd4, 0, 2, 4};
    vecs[2] = '{1'b1, 32'h0000_0200, 5'd0, 1, 0, 1};
    vecs[3] = '{1'b0, 32'hFFFF_FFFC, 5'd2, 0, 0, 2};
    vecs[4] = '{1'b1, 32'h0000_0103, 5'd3, 3, 1, 3};
    vecs[5] = '{1'b1, 32'h0000_0400, 5'd2, 3, 0, 2};
    vecs[6] = '{1'b1, 32'h0000_0500, 5'd1, 0, 0, 1};
    vecs[7] = '{1'b0, 32'h0000_0044, 5'd0, 0, 1, 1};
    vecs[8] = '{1'b1, 32'hFFFF_FFF8, 5'd3, 3, 0, 3};

    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wdat_ready", wdat_ready, 1);
    check("rst_cyc", wb.wb_cyc_o, 0);
    check("rst_stb", wb.wb_stb_o, 0);
    check("rst_cti", wb.wb_cti_o, 0);
    check("rst_addr", wb.wb_addr_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdat_valid", rdat_valid, 0);
    RESETN = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      wait_states = vecs[v].ws;
      for (int j = 0; j < vecs[v].nw; j++) push_word();
      d0 = done_cnt;
      b0 = beats_seen;
      issue_cmd(vecs[v].we, vecs[v].addr, vecs[v].bl);
      wait_done(d0);
      tick();
      check($sformatf("v%0d_beats", v), beats_seen - b0, vecs[v].exp_nb);
      check($sformatf("v%0d_busy", v), busy, 0);
      check($sformatf("v%0d_exp_left", v), exp_beats.size(), 0);
      check($sformatf("v%0d_rd_left", v), exp_rd.size(), 0);
    end
    check("fifo_drained", wq.size(), 0);

    // Starvation: one word queued for a 3-beat write.
    wait_states = 0;
    wval = 32'hB0;
    push_word();
    d0 = done_cnt;
    b0 = beats_seen;
    issue_cmd(1'b1, 32'h0000_0300, 5'd3);
    repeat (5) tick();
    check("starve_cyc", wb.wb_cyc_o, 1);
    check("starve_stb", wb.wb_stb_o, 0);
    check("starve_busy", busy, 1);
    check("starve_beats", beats_seen - b0, 1);
    push_word();
    push_word();
    wait_done(d0);
    tick();
    check("starve_total_beats", beats_seen - b0, 3);
    check("starve_exp_left", exp_beats.size(), 0);

    // Reset during beat 2 of an 8-beat write.
    wval = 32'hC0;
    for (int j = 0; j < 8; j++) push_word();
    d0 = done_cnt;
    b0 = beats_seen;
    issue_cmd(1'b1, 32'h0000_0600, 5'd8);
    for (int k = 0; k < 20; k++) begin
      if (beats_seen - b0 >= 1) break;
      tick();
    end
    check("midrst_before", beats_seen - b0, 1);
    RESETN = 1'b0;
    tick();
    check("midrst_cyc", wb.wb_cyc_o, 0);
    check("midrst_stb", wb.wb_stb_o, 0);
    check("midrst_wdat_ready", wdat_ready, 1);
    check("midrst_busy", busy, 0);
    exp_beats.delete();
    wq.delete();
    RESETN = 1'b1;
    tick();
    check("midrst_no_done", done_cnt, d0);
    d0 = done_cnt;
    b0 = beats_seen;
    issue_cmd(1'b0, 32'h0000_0080, 5'd1);
    wait_done(d0);
    tick();
    check("postrst_beats", beats_seen - b0, 1);
    check("postrst_rd_left", exp_rd.size(), 0);

`ifdef WBM_TIMEOUT_EN
    begin
      int k;
      bit seen;
      never_ack = 1;
      d0 = done_cnt;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h700; cmd_bl = 5'd2;
      tick();
      cmd_valid = 1'b0;
      check("to_stb_rise", wb.wb_stb_o, 1);
      seen = 0;
      for (k = 1; k <= 40; k++) begin
        tick();
        if (err) begin seen = 1; break; end
      end
      if (!seen) fail("to_err_timeout");
      else check("to_err_cycle", k, 16);
      check("to_cyc", wb.wb_cyc_o, 0);
      check("to_busy", busy, 0);
      tick();
      check("to_err_pulse", err, 0);
      check("to_no_done", done_cnt, d0);
      never_ack = 0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
